// File: rtl/pong_pkg.sv
// Shared types and constants for the pong scoring logic.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  localparam int MAX_SCORE = 99;

  // Bit positions inside digit_on, ordered {left_tens, left_ones, right_tens, right_ones}.
  localparam int DIG_LEFT_TENS  = 3;
  localparam int DIG_LEFT_ONES  = 2;
  localparam int DIG_RIGHT_TENS = 1;
  localparam int DIG_RIGHT_ONES = 0;

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter with a binary shadow copy, saturating at MAX_SCORE.
// Next-state values are exported so the parent can decide on the same edge.
module bcd_counter2
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] bin,
  output logic [3:0] tens_next,
  output logic [3:0] ones_next,
  output logic [6:0] bin_next
);

  logic [3:0] tens_reg;
  logic [3:0] ones_reg;
  logic [6:0] bin_reg;

  always_comb begin
    tens_next = tens_reg;
    ones_next = ones_reg;
    bin_next  = bin_reg;
    if (clr) begin
      tens_next = 4'd0;
      ones_next = 4'd0;
      bin_next  = 7'd0;
    end else if (inc && (bin_reg < 7'(MAX_SCORE))) begin
      bin_next = bin_reg + 7'd1;
      if (ones_reg == 4'd9) begin
        ones_next = 4'd0;
        tens_next = tens_reg + 4'd1;
      end else begin
        ones_next = ones_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tens_reg <= 4'd0;
      ones_reg <= 4'd0;
      bin_reg  <= 7'd0;
    end else begin
      tens_reg <= tens_next;
      ones_reg <= ones_next;
      bin_reg  <= bin_next;
    end
  end

  assign tens = tens_reg;
  assign ones = ones_reg;
  assign bin  = bin_reg;

endmodule

// File: rtl/score_keeper.sv
// Pong match scoring: per-player BCD scores, win rule, serve rotation,
// leading-zero suppression and game-over blink of the winner's digits.
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE  = 11,
  parameter int WIN_BY_TWO = 1,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       point_left,
  input  logic       point_right,
  input  logic       new_game,
  output logic [3:0] left_tens,
  output logic [3:0] left_ones,
  output logic [3:0] right_tens,
  output logic [3:0] right_ones,
  output logic [3:0] digit_on,
  output logic       serve_right,
  output logic       game_over,
  output logic       winner_right
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t           state_reg, state_next;
  logic             serve_reg, serve_next;
  logic             winner_reg, winner_next;
  logic             game_over_reg;
  logic             phase_reg, phase_next;
  logic [CNT_W-1:0] blink_cnt_reg, blink_cnt_next;
  logic [3:0]       digit_on_reg, digit_on_next;

  logic       accept, inc_left, inc_right;
  logic [6:0] left_bin, right_bin, left_bin_next, right_bin_next;
  logic [3:0] left_tens_next, left_ones_next, right_tens_next, right_ones_next;
  logic       win_left, win_right, deuce, serve_toggle;
  logic [7:0] total_next;

  // A point counts only in PLAY, only when unambiguous, and never alongside new_game.
  assign accept    = (state_reg == PLAY) && !new_game && (point_left ^ point_right);
  assign inc_left  = accept && point_left;
  assign inc_right = accept && point_right;

  bcd_counter2 u_left (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc_left),
    .clr       (new_game),
    .tens      (left_tens),
    .ones      (left_ones),
    .bin       (left_bin),
    .tens_next (left_tens_next),
    .ones_next (left_ones_next),
    .bin_next  (left_bin_next)
  );

  bcd_counter2 u_right (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc_right),
    .clr       (new_game),
    .tens      (right_tens),
    .ones      (right_ones),
    .bin       (right_bin),
    .tens_next (right_tens_next),
    .ones_next (right_ones_next),
    .bin_next  (right_bin_next)
  );

  // Scoring at the 99 ceiling ends the game outright so deuce cannot run forever.
  always_comb begin
    win_left  = inc_left && ((left_bin == 7'(MAX_SCORE)) ||
                ((int'(left_bin_next) >= WIN_SCORE) &&
                 ((WIN_BY_TWO == 0) || (int'(left_bin_next) >= int'(right_bin_next) + 2))));
    win_right = inc_right && ((right_bin == 7'(MAX_SCORE)) ||
                ((int'(right_bin_next) >= WIN_SCORE) &&
                 ((WIN_BY_TWO == 0) || (int'(right_bin_next) >= int'(left_bin_next) + 2))));
    total_next   = {1'b0, left_bin_next} + {1'b0, right_bin_next};
    deuce        = (int'(left_bin_next) >= WIN_SCORE - 1) && (int'(right_bin_next) >= WIN_SCORE - 1);
    serve_toggle = accept && (deuce || !total_next[0]);
  end

  always_comb begin
    state_next  = state_reg;
    serve_next  = serve_reg;
    winner_next = winner_reg;
    case (state_reg)
      IDLE: begin
        if (new_game) begin
          state_next = PLAY;
          serve_next = 1'b0;
        end
      end
      PLAY: begin
        if (new_game) begin
          serve_next = 1'b0;
        end else if (accept) begin
          serve_next = serve_reg ^ serve_toggle;
          if (win_left || win_right) begin
            state_next  = GAME_OVER;
            winner_next = win_right;
          end
        end
      end
      GAME_OVER: begin
        if (new_game) begin
          state_next  = PLAY;
          serve_next  = 1'b0;
          winner_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Blink phase is 1 on the entry edge and flips every BLINK_DIV cycles thereafter.
  always_comb begin
    blink_cnt_next = '0;
    phase_next     = 1'b0;
    if (state_next == GAME_OVER) begin
      if (state_reg != GAME_OVER) begin
        phase_next = 1'b1;
      end else if (blink_cnt_reg == CNT_W'(BLINK_DIV - 1)) begin
        phase_next = ~phase_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + 1'b1;
        phase_next     = phase_reg;
      end
    end
  end

  always_comb begin
    digit_on_next                 = 4'b0000;
    digit_on_next[DIG_LEFT_TENS]  = (left_tens_next != 4'd0);
    digit_on_next[DIG_LEFT_ONES]  = 1'b1;
    digit_on_next[DIG_RIGHT_TENS] = (right_tens_next != 4'd0);
    digit_on_next[DIG_RIGHT_ONES] = 1'b1;
    if (state_next == GAME_OVER) begin
      if (winner_next) begin
        digit_on_next[DIG_RIGHT_TENS] = digit_on_next[DIG_RIGHT_TENS] & phase_next;
        digit_on_next[DIG_RIGHT_ONES] = phase_next;
      end else begin
        digit_on_next[DIG_LEFT_TENS]  = digit_on_next[DIG_LEFT_TENS] & phase_next;
        digit_on_next[DIG_LEFT_ONES]  = phase_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      serve_reg     <= 1'b0;
      winner_reg    <= 1'b0;
      game_over_reg <= 1'b0;
      phase_reg     <= 1'b0;
      blink_cnt_reg <= '0;
      digit_on_reg  <= 4'b0101;
    end else begin
      state_reg     <= state_next;
      serve_reg     <= serve_next;
      winner_reg    <= winner_next;
      game_over_reg <= (state_next == GAME_OVER);
      phase_reg     <= phase_next;
      blink_cnt_reg <= blink_cnt_next;
      digit_on_reg  <= digit_on_next;
    end
  end

  assign digit_on     = digit_on_reg;
  assign serve_right  = serve_reg;
  assign game_over    = game_over_reg;
  assign winner_right = winner_reg;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: two instances, one with a fast blink and
// default win rule, one with WIN_SCORE=99 to exercise the saturation win.
module tb_score_keeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic point_left = 1'b0;
  logic point_right = 1'b0;
  logic new_game = 1'b0;

  logic [3:0] a_lt, a_lo, a_rt, a_ro, a_don;
  logic       a_srv, a_go, a_win;
  logic [3:0] b_lt, b_lo, b_rt, b_ro, b_don;
  logic       b_srv, b_go, b_win;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  score_keeper #(.WIN_SCORE(11), .WIN_BY_TWO(1), .BLINK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .point_left(point_left), .point_right(point_right),
    .new_game(new_game), .left_tens(a_lt), .left_ones(a_lo), .right_tens(a_rt),
    .right_ones(a_ro), .digit_on(a_don), .serve_right(a_srv), .game_over(a_go),
    .winner_right(a_win)
  );

  score_keeper #(.WIN_SCORE(99), .WIN_BY_TWO(1), .BLINK_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .point_left(point_left), .point_right(point_right),
    .new_game(new_game), .left_tens(b_lt), .left_ones(b_lo), .right_tens(b_rt),
    .right_ones(b_ro), .digit_on(b_don), .serve_right(b_srv), .game_over(b_go),
    .winner_right(b_win)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives for one rising edge and returns at the next negedge.
  task automatic pulse(input logic l, input logic r, input logic ng);
    point_left  = l;
    point_right = r;
    new_game    = ng;
    @(negedge clk);
    point_left  = 1'b0;
    point_right = 1'b0;
    new_game    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_digits", {16'd0, a_lt, a_lo, a_rt, a_ro}, 32'h0000);
    chk("rst_flags", {29'd0, a_srv, a_go, a_win}, 32'd0);
    chk("rst_digit_on", {28'd0, a_don}, 32'b0101);

    // Points in IDLE are ignored
    for (int i = 0; i < 12; i++) pulse(1'b1, 1'b0, 1'b0);
    chk("idle_ignored", {16'd0, a_lt, a_lo, a_rt, a_ro}, 32'h0000);
    pulse(1'b0, 1'b0, 1'b1);
    chk("ng_digits", {16'd0, a_lt, a_lo, a_rt, a_ro}, 32'h0000);
    chk("ng_digit_on", {28'd0, a_don}, 32'b0101);
    chk("ng_game_over", {31'd0, a_go}, 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("play_first_point", {16'd0, a_lt, a_lo, a_rt, a_ro}, 32'h0100);

    // Serve rotation from a fresh game: R,R,L,R -> 0,1,1,0
    pulse(1'b0, 1'b0, 1'b1);
    chk("ng_in_play_clears", {16'd0, a_lt, a_lo, a_rt, a_ro}, 32'h0000);
    pulse(1'b0, 1'b1, 1'b0);
    chk("serve_p1", {31'd0, a_srv}, 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("serve_p2", {31'd0, a_srv}, 32'd1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("serve_p3", {31'd0, a_srv}, 32'd1);
    pulse(1'b0, 1'b1, 1'b0);
    chk("serve_p4", {31'd0, a_srv}, 32'd0);
    chk("score_1_3", {16'd0, a_lt, a_lo, a_rt, a_ro}, 32'h0103);
    chk("tens_off_1_3", {28'd0, a_don}, 32'b0101);

    // Simultaneous points at 5-5 are dropped
    pulse(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
    end
    chk("score_5_5", {16'd0, a_lt, a_lo, a_rt, a_ro}, 32'h0505);
    chk("serve_5_5", {31'd0, a_srv}, 32'd1);
    pulse(1'b1, 1'b1, 1'b0);
    chk("both_score", {16'd0, a_lt, a_lo, a_rt, a_ro}, 32'h0505);
    chk("both_serve", {31'd0, a_srv}, 32'd1);

    // Deuce game: 10-10, then L,R,L,L -> 13-11 left wins
    pulse(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0, 1'b0);
    chk("left_10_no_win", {31'd0, a_go}, 32'd0);
    for (int i = 0; i < 10; i++) pulse(1'b0, 1'b1, 1'b0);
    chk("score_10_10", {16'd0, a_lt, a_lo, a_rt, a_ro}, 32'h1010);
    chk("digit_on_10_10", {28'd0, a_don}, 32'b1111);
    chk("serve_10_10", {31'd0, a_srv}, 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("serve_11_10", {31'd0, a_srv}, 32'd1);
    pulse(1'b0, 1'b1, 1'b0);
    chk("serve_11_11", {31'd0, a_srv}, 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("serve_12_11", {31'd0, a_srv}, 32'd1);
    chk("no_win_12_11", {31'd0, a_go}, 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("serve_13_11", {31'd0, a_srv}, 32'd0);
    chk("score_13_11", {16'd0, a_lt, a_lo, a_rt, a_ro}, 32'h1311);
    chk("deuce_game_over", {30'd0, a_go, a_win}, 32'b10);

    // Right wins 11-3 with BLINK_DIV=4
    pulse(1'b0, 1'b0, 1'b1);
    chk("ng_from_over", {31'd0, a_go}, 32'd0);
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) pulse(1'b0, 1'b1, 1'b0);
    chk("score_3_11", {16'd0, a_lt, a_lo, a_rt, a_ro}, 32'h0311);
    chk("right_wins", {30'd0, a_go, a_win}, 32'b11);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("blink_c%0d", i), {28'd0, a_don},
          ((i / 4) % 2 == 0) ? 32'b0111 : 32'b0100);
      @(negedge clk);
    end
    pulse(1'b1, 1'b0, 1'b0);
    chk("over_point_ignored", {16'd0, a_lt, a_lo, a_rt, a_ro}, 32'h0311);
    pulse(1'b0, 1'b0, 1'b1);
    chk("ng_after_win_digits", {16'd0, a_lt, a_lo, a_rt, a_ro}, 32'h0000);
    chk("ng_after_win_flags", {28'd0, a_don}, 32'b0101);
    chk("ng_after_win_go", {31'd0, a_go}, 32'd0);

    // Reset mid-game overrides a same-cycle point, then IDLE ignores points
    pulse(1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    pulse(1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    chk("mid_rst_digits", {16'd0, a_lt, a_lo, a_rt, a_ro}, 32'h0000);
    pulse(1'b1, 1'b0, 1'b0);
    chk("mid_rst_idle", {16'd0, a_lt, a_lo, a_rt, a_ro}, 32'h0000);

    // WIN_SCORE=99: 99-98 does not win; next left point wins at saturation
    do_reset();
    pulse(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 98; i++) pulse(1'b1, 1'b0, 1'b0);
    chk("b_left_98", {24'd0, b_lt, b_lo}, 32'h98);
    chk("b_no_win_98_0", {31'd0, b_go}, 32'd0);
    for (int i = 0; i < 98; i++) pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("b_score_99_98", {16'd0, b_lt, b_lo, b_rt, b_ro}, 32'h9998);
    chk("b_no_win_99_98", {31'd0, b_go}, 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("b_sat_score", {16'd0, b_lt, b_lo, b_rt, b_ro}, 32'h9998);
    chk("b_sat_win", {30'd0, b_go, b_win}, 32'b10);
    chk("b_sat_digit_on", {28'd0, b_don}, 32'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
